// File: rtl/pll_lock_pkg.sv
// Shared encodings and helpers for the PLL lock detector.
package pll_lock_pkg;

  localparam int ERR_W = 33;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACQ    = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  // Magnitude of a signed period error; fits unsigned in ERR_W bits.
  function automatic logic [ERR_W-1:0] err_mag(input logic signed [ERR_W-1:0] e);
    return e[ERR_W-1] ? ERR_W'(-e) : ERR_W'(e);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Brings the measured clock into the reference domain and emits a one-cycle
// pulse per rising edge, 2-3 reference cycles after the edge.
module pll_lock_sync (
  input  logic clk,
  input  logic RST_N,
  input  logic async_in,
  output logic edge_pulse
);

  // [0],[1] are the synchronizer flops, [2] is the edge-detect history.
  logic [2:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync_q     <= '0;
      edge_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[1:0], async_in};
      edge_pulse <= sync_q[1] & ~sync_q[2];
    end
  end

endmodule

// File: rtl/pll_lock_detect.sv
// Lock detector: compares each measured period against the expected period
// and tracks acquisition, lock, loss of lock and measured-clock stall.
module pll_lock_detect
  import pll_lock_pkg::*;
#(
  parameter int unsigned LOCK_COUNT     = 8,
  parameter int unsigned UNLOCK_COUNT   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    RST_N,
  input  logic                    PWRDWN,
  input  logic                    sample_clk,
  input  logic [31:0]             period_length_1000,
  input  logic [31:0]             expected_period_1000,
  input  logic [31:0]             tolerance_1000,
  input  logic                    clr_lost,
  output logic                    LOCKED,
  output logic                    lock_lost,
  output logic signed [ERR_W-1:0] period_error,
  output logic [1:0]              state
);

  localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_LIM = CNT_W'(UNLOCK_COUNT);
  localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic                    edge_pulse;
  logic signed [ERR_W-1:0] err;
  logic                    match;
  logic [CNT_W-1:0]        match_cnt;
  logic [CNT_W-1:0]        miss_cnt;
  logic [CNT_W-1:0]        tmo_cnt;

  pll_lock_sync u_sync (
    .clk        (clk),
    .RST_N      (RST_N),
    .async_in   (sample_clk),
    .edge_pulse (edge_pulse)
  );

  // NOTE: every signal written here gets a value on every path, so no latch.
  always_comb begin
    err   = $signed({1'b0, period_length_1000}) - $signed({1'b0, expected_period_1000});
    match = (period_length_1000 != 32'd0) && (err_mag(err) <= {1'b0, tolerance_1000});
  end

  assign LOCKED = (state == ST_LOCKED);

  // Priority: power-down, then stall timeout, then the sampled edge.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state        <= ST_IDLE;
      lock_lost    <= 1'b0;
      period_error <= '0;
      match_cnt    <= '0;
      miss_cnt     <= '0;
      tmo_cnt      <= '0;
    end else begin
      // Any lock-loss set below overrides this clear.
      if (clr_lost) lock_lost <= 1'b0;

      if (PWRDWN) begin
        state        <= ST_IDLE;
        period_error <= '0;
        match_cnt    <= '0;
        miss_cnt     <= '0;
        tmo_cnt      <= '0;
      end else if (tmo_cnt == TMO_LIM) begin
        state     <= ST_IDLE;
        match_cnt <= '0;
        miss_cnt  <= '0;
        tmo_cnt   <= '0;
        if (state == ST_LOCKED) lock_lost <= 1'b1;
      end else if (edge_pulse) begin
        tmo_cnt      <= '0;
        period_error <= err;
        case (state)
          ST_IDLE: begin
            // First edge after idle measures a partial period; discard it.
            state     <= ST_ACQ;
            match_cnt <= '0;
            miss_cnt  <= '0;
          end
          ST_ACQ: begin
            if (!match) begin
              match_cnt <= '0;
            end else if (match_cnt + CNT_ONE == LOCK_LIM) begin
              state     <= ST_LOCKED;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + CNT_ONE;
            end
          end
          ST_LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
            end else if (miss_cnt + CNT_ONE == UNLOCK_LIM) begin
              state     <= ST_ACQ;
              miss_cnt  <= '0;
              lock_lost <= 1'b1;
            end else begin
              miss_cnt <= miss_cnt + CNT_ONE;
            end
          end
          default: begin
            state     <= ST_IDLE;
            match_cnt <= '0;
            miss_cnt  <= '0;
          end
        endcase
      end else if (tmo_cnt != '1) begin
        tmo_cnt <= tmo_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for pll_lock_detect: acquisition, loss, stall, boundaries, reset.
`timescale 1ns/10ps
module tb_pll_lock_detect;

  logic               clk = 1'b0;
  logic               RST_N = 1'b0;
  logic               PWRDWN = 1'b0;
  logic               sample_clk = 1'b0;
  logic [31:0]        period_length_1000 = '0;
  logic [31:0]        expected_period_1000 = '0;
  logic [31:0]        tolerance_1000 = '0;
  logic               clr_lost = 1'b0;
  logic               LOCKED;
  logic               lock_lost;
  logic signed [32:0] period_error;
  logic [1:0]         state;

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_detect dut (
    .clk                  (clk),
    .RST_N                (RST_N),
    .PWRDWN               (PWRDWN),
    .sample_clk           (sample_clk),
    .period_length_1000   (period_length_1000),
    .expected_period_1000 (expected_period_1000),
    .tolerance_1000       (tolerance_1000),
    .clr_lost             (clr_lost),
    .LOCKED               (LOCKED),
    .lock_lost            (lock_lost),
    .period_error         (period_error),
    .state                (state)
  );

  always #0.5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sample_clk period of 10 clk cycles, presenting meas on the rising edge.
  task automatic sample_edge(input logic [31:0] meas);
    @(negedge clk);
    period_length_1000 = meas;
    sample_clk = 1'b1;
    repeat (5) @(negedge clk);
    sample_clk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic edges(input logic [31:0] meas, input int n);
    for (int i = 0; i < n; i++) sample_edge(meas);
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] st, input logic lk,
                               input logic lost);
    check({tag, ".state"}, 33'(state), 33'(st));
    check({tag, ".LOCKED"}, 33'(LOCKED), 33'(lk));
    check({tag, ".lock_lost"}, 33'(lock_lost), 33'(lost));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs("rst", 2'b00, 1'b0, 1'b0);
    check("rst.err", period_error, 33'd0);
    RST_N = 1'b1;
    repeat (2) @(negedge clk);

    // 1: steady in-tolerance period, discard + 8 counted edges to lock
    expected_period_1000 = 32'd10000;
    tolerance_1000       = 32'd50;
    sample_edge(32'd10020);
    check_outputs("t1.discard", 2'b01, 1'b0, 1'b0);
    check("t1.err", period_error, 33'd20);
    edges(32'd10020, 7);
    check_outputs("t1.seven", 2'b01, 1'b0, 1'b0);
    sample_edge(32'd10020);
    check_outputs("t1.eight", 2'b10, 1'b1, 1'b0);

    // 2: a single miss is forgiven; two consecutive misses drop lock
    sample_edge(32'd10100);
    check_outputs("t2.miss1", 2'b10, 1'b1, 1'b0);
    check("t2.err", period_error, 33'd100);
    sample_edge(32'd10000);
    check("t2.err0", period_error, 33'd0);
    sample_edge(32'd10100);
    check_outputs("t2.miss_again", 2'b10, 1'b1, 1'b0);
    sample_edge(32'd10100);
    check_outputs("t2.drop", 2'b01, 1'b0, 1'b1);

    // 3: clear, relock, then stall the measured clock
    @(negedge clk); clr_lost = 1'b1;
    @(negedge clk); clr_lost = 1'b0;
    check("t3.clr", 33'(lock_lost), 33'd0);
    edges(32'd10020, 7);
    check_outputs("t3.relock7", 2'b01, 1'b0, 1'b0);
    sample_edge(32'd10020);
    check_outputs("t3.relock8", 2'b10, 1'b1, 1'b0);
    repeat (1000) @(negedge clk);
    check_outputs("t3.before_tmo", 2'b10, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check_outputs("t3.tmo", 2'b00, 1'b0, 1'b1);
    clr_lost = 1'b1;
    @(negedge clk); clr_lost = 1'b0;
    check("t3.clr2", 33'(lock_lost), 33'd0);

    // 4: zero period with zero expectation and tolerance never locks
    expected_period_1000 = 32'd0;
    tolerance_1000       = 32'd0;
    edges(32'd0, 12);
    check_outputs("t4.zero", 2'b01, 1'b0, 1'b0);
    check("t4.err", period_error, 33'd0);

    // 5: tolerance boundary, +/-50 match, +51 misses
    expected_period_1000 = 32'd10000;
    tolerance_1000       = 32'd50;
    sample_edge(32'd9950);
    check("t5.err_neg50", period_error, -33'sd50);
    sample_edge(32'd10050);
    check("t5.err_pos50", period_error, 33'd50);
    for (int i = 0; i < 5; i++) sample_edge((i % 2) ? 32'd10050 : 32'd9950);
    check_outputs("t5.seven", 2'b01, 1'b0, 1'b0);
    sample_edge(32'd10051);
    check("t5.err_pos51", period_error, 33'd51);
    check_outputs("t5.miss51", 2'b01, 1'b0, 1'b0);
    edges(32'd9950, 7);
    check_outputs("t5.post_miss7", 2'b01, 1'b0, 1'b0);
    sample_edge(32'd10050);
    check_outputs("t5.lock", 2'b10, 1'b1, 1'b0);

    // 6a: power-down while locked drops lock without flagging loss
    @(negedge clk); PWRDWN = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("t6.pwrdwn", 2'b00, 1'b0, 1'b0);
    check("t6.pwrdwn_err", period_error, 33'd0);
    PWRDWN = 1'b0;
    edges(32'd10020, 8);
    check_outputs("t6.pd_relock8", 2'b01, 1'b0, 1'b0);
    sample_edge(32'd10020);
    check_outputs("t6.pd_relock9", 2'b10, 1'b1, 1'b0);

    // 6b: lose lock, reacquire partway, then reset asynchronously
    edges(32'd10100, 2);
    check_outputs("t6.drop", 2'b01, 1'b0, 1'b1);
    edges(32'd10020, 5);
    check("t6.pre_rst_err", period_error, 33'd20);
    @(posedge clk); #0.2;
    RST_N = 1'b0;
    #0.1;
    check_outputs("t6.async_rst", 2'b00, 1'b0, 1'b0);
    check("t6.async_rst_err", period_error, 33'd0);
    @(negedge clk); RST_N = 1'b1;
    edges(32'd10020, 8);
    check_outputs("t6.rst_relock8", 2'b01, 1'b0, 1'b0);
    sample_edge(32'd10020);
    check_outputs("t6.rst_relock9", 2'b10, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
